// File: rtl/dest_pipe_tracker_pkg.sv
// -----------------------------------------------------------------------------
// dest_pipe_tracker_pkg
// Shared pipeline definitions for the destination-register tracker:
//   REG_W          register-index width used by every Dest field
//   stage_entry_t  one pipeline slot {dest, wb_en, mem_r_en}
//   BUBBLE         empty slot (all fields zero)
//   make_entry()   packs ID-stage fields into a slot
// -----------------------------------------------------------------------------
package dest_pipe_tracker_pkg;

    localparam int REG_W = 4;

    typedef struct packed {
        logic [REG_W-1:0] dest;
        logic             wb_en;
        logic             mem_r_en;
    } stage_entry_t;

    localparam stage_entry_t BUBBLE = '{dest: '0, wb_en: 1'b0, mem_r_en: 1'b0};

    function automatic stage_entry_t make_entry(
        input logic [REG_W-1:0] dest,
        input logic             wb_en,
        input logic             mem_r_en
    );
        stage_entry_t e;
        e.dest     = dest;
        e.wb_en    = wb_en;
        e.mem_r_en = mem_r_en;
        return e;
    endfunction

endpackage

// File: rtl/dest_pipe_tracker_if.sv
// -----------------------------------------------------------------------------
// dest_pipe_tracker_if
// Bundle between the pipeline control (master) and the tracker (slave).
//   master drives : ID_Dest, ID_WB_EN, ID_MEM_R_EN, Hazard, Flush, Freeze
//   slave drives  : EXE/MEM/WB_Dest, EXE/MEM/WB_WB_EN, EXE_MEM_R_EN,
//                   HZ_EXE_WB_EN, HZ_MEM_WB_EN, stall_cnt, flush_cnt
// Parameter CNT_W sets the performance-counter width.
// -----------------------------------------------------------------------------
interface dest_pipe_tracker_if
    import dest_pipe_tracker_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] ID_Dest;
    logic             ID_WB_EN;
    logic             ID_MEM_R_EN;
    logic             Hazard;
    logic             Flush;
    logic             Freeze;

    logic [REG_W-1:0] EXE_Dest;
    logic [REG_W-1:0] MEM_Dest;
    logic [REG_W-1:0] WB_Dest;
    logic             EXE_WB_EN;
    logic             MEM_WB_EN;
    logic             WB_WB_EN;
    logic             EXE_MEM_R_EN;
    logic             HZ_EXE_WB_EN;
    logic             HZ_MEM_WB_EN;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ID_Dest, ID_WB_EN, ID_MEM_R_EN, Hazard, Flush, Freeze,
        input  EXE_Dest, MEM_Dest, WB_Dest, EXE_WB_EN, MEM_WB_EN, WB_WB_EN,
               EXE_MEM_R_EN, HZ_EXE_WB_EN, HZ_MEM_WB_EN, stall_cnt, flush_cnt
    );

    modport slave (
        input  ID_Dest, ID_WB_EN, ID_MEM_R_EN, Hazard, Flush, Freeze,
        output EXE_Dest, MEM_Dest, WB_Dest, EXE_WB_EN, MEM_WB_EN, WB_WB_EN,
               EXE_MEM_R_EN, HZ_EXE_WB_EN, HZ_MEM_WB_EN, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/dest_pipe_tracker_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter; sticks at 2^CNT_W-1 instead of wrapping.
//   clk, rst_n  clock / async active-low reset (clears count)
//   enable      count this cycle
//   hold        freeze the count (overrides enable)
//   count       registered count value
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             hold,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (enable && !hold && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/dest_pipe_tracker.sv
// -----------------------------------------------------------------------------
// dest_pipe_tracker
// Three-slot shift pipeline (EXE -> MEM -> WB) tracking the destination
// register and enables of in-flight instructions, plus saturating stall and
// flush counters.
//   clk     single clock, rising edge
//   rst_n   async active-low reset; clears all slots and counters
//   bus     dest_pipe_tracker_if.slave (ID inputs, stall controls, stage
//           outputs, hazard-unit enables, counters)
// Build option: define FWD_EN for forwarding-aware hazard enables
// (only a load in EXE is reported; MEM is never reported). True stage
// outputs and counters do not depend on FWD_EN.
// All outputs come straight from flops, including the hazard enables, which
// are computed from the next-state slots and registered alongside them.
// -----------------------------------------------------------------------------
module dest_pipe_tracker
    import dest_pipe_tracker_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dest_pipe_tracker_if.slave   bus
);

    stage_entry_t exe_q, exe_d;
    stage_entry_t mem_q, mem_d;
    stage_entry_t wb_q,  wb_d;
    logic         hz_exe_q, hz_exe_d;
    logic         hz_mem_q, hz_mem_d;

    logic         stall_inc;
    logic         flush_inc;

    always_comb begin
        exe_d = exe_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!bus.Freeze) begin
            wb_d  = mem_q;
            mem_d = exe_q;
            // Flush and Hazard both squash the ID instruction into a bubble.
            if (bus.Hazard || bus.Flush) begin
                exe_d = BUBBLE;
            end else begin
                exe_d = make_entry(bus.ID_Dest, bus.ID_WB_EN, bus.ID_MEM_R_EN);
            end
        end
    end

    always_comb begin
`ifdef FWD_EN
        hz_exe_d = exe_d.wb_en & exe_d.mem_r_en;
        hz_mem_d = 1'b0;
`else
        hz_exe_d = exe_d.wb_en;
        hz_mem_d = mem_d.wb_en;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_q    <= BUBBLE;
            mem_q    <= BUBBLE;
            wb_q     <= BUBBLE;
            hz_exe_q <= 1'b0;
            hz_mem_q <= 1'b0;
        end else begin
            exe_q    <= exe_d;
            mem_q    <= mem_d;
            wb_q     <= wb_d;
            hz_exe_q <= hz_exe_d;
            hz_mem_q <= hz_mem_d;
        end
    end

    // A flush takes precedence: a cycle with both requests counts as a flush.
    assign stall_inc = bus.Hazard & ~bus.Flush;
    assign flush_inc = bus.Flush;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (stall_inc),
        .hold   (bus.Freeze),
        .count  (bus.stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (flush_inc),
        .hold   (bus.Freeze),
        .count  (bus.flush_cnt)
    );

    assign bus.EXE_Dest     = exe_q.dest;
    assign bus.MEM_Dest     = mem_q.dest;
    assign bus.WB_Dest      = wb_q.dest;
    assign bus.EXE_WB_EN    = exe_q.wb_en;
    assign bus.MEM_WB_EN    = mem_q.wb_en;
    assign bus.WB_WB_EN     = wb_q.wb_en;
    assign bus.EXE_MEM_R_EN = exe_q.mem_r_en;
    assign bus.HZ_EXE_WB_EN = hz_exe_q;
    assign bus.HZ_MEM_WB_EN = hz_mem_q;

endmodule

// File: tb/tb_dest_pipe_tracker.sv
// -----------------------------------------------------------------------------
// tb_dest_pipe_tracker
// Directed bench for dest_pipe_tracker. Two instances share one stimulus:
// u_dut (CNT_W=16) and u_dut_s (CNT_W=2, for counter saturation).
// Honors FWD_EN for the hazard-unit enable expectations.
// -----------------------------------------------------------------------------
module tb_dest_pipe_tracker;
    import dest_pipe_tracker_pkg::*;

    logic clk;
    logic rst_n;

    int n_cmp = 0;
    int n_err = 0;

    dest_pipe_tracker_if #(.CNT_W(16)) bus   ();
    dest_pipe_tracker_if #(.CNT_W(2))  bus_s ();

    dest_pipe_tracker #(.CNT_W(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    dest_pipe_tracker #(.CNT_W(2)) u_dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] dest, input logic wb, input logic mr,
                         input logic hz, input logic fl, input logic fz);
        bus.ID_Dest       = dest;
        bus.ID_WB_EN      = wb;
        bus.ID_MEM_R_EN   = mr;
        bus.Hazard        = hz;
        bus.Flush         = fl;
        bus.Freeze        = fz;
        bus_s.ID_Dest     = dest;
        bus_s.ID_WB_EN    = wb;
        bus_s.ID_MEM_R_EN = mr;
        bus_s.Hazard      = hz;
        bus_s.Flush       = fl;
        bus_s.Freeze      = fz;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Snapshot of every output of the main instance, packed for compact compares.
    function automatic logic [31:0] all_out();
        return {bus.EXE_Dest, bus.MEM_Dest, bus.WB_Dest, bus.EXE_WB_EN, bus.MEM_WB_EN,
                bus.WB_WB_EN, bus.EXE_MEM_R_EN, bus.HZ_EXE_WB_EN, bus.HZ_MEM_WB_EN};
    endfunction

    logic [31:0] snap;
    logic        exp_hz_exe_nl;
    logic        exp_hz_mem;

    initial begin
`ifdef FWD_EN
        exp_hz_exe_nl = 1'b0;
        exp_hz_mem    = 1'b0;
`else
        exp_hz_exe_nl = 1'b1;
        exp_hz_mem    = 1'b1;
`endif
        rst_n = 1'b0;
        drive(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst_outs",      all_out(),       32'd0);
        chk("rst_stall",     bus.stall_cnt,   32'd0);
        chk("rst_flush",     bus.flush_cnt,   32'd0);

        // Single instruction Dest=5 walks EXE -> MEM -> WB.
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("e1_exe_dest",   bus.EXE_Dest,    32'd5);
        chk("e1_exe_wb",     bus.EXE_WB_EN,   32'd1);
        chk("e1_mem_dest",   bus.MEM_Dest,    32'd0);
        drive(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("e2_exe_dest",   bus.EXE_Dest,    32'd0);
        chk("e2_mem_dest",   bus.MEM_Dest,    32'd5);
        chk("e2_mem_wb",     bus.MEM_WB_EN,   32'd1);
        tick();
        chk("e3_mem_dest",   bus.MEM_Dest,    32'd0);
        chk("e3_wb_dest",    bus.WB_Dest,     32'd5);
        chk("e3_wb_wb",      bus.WB_WB_EN,    32'd1);
        tick();
        chk("e4_zeros",      all_out(),       32'd0);

        // Dest=3 non-load into EXE, then a hazard cycle.
        drive(4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("d3_exe_dest",   bus.EXE_Dest,    32'd3);
        chk("d3_hz_exe",     bus.HZ_EXE_WB_EN, {31'd0, exp_hz_exe_nl});
        chk("d3_hz_mem",     bus.HZ_MEM_WB_EN, 32'd0);
        drive(4'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("hz_exe_dest",   bus.EXE_Dest,    32'd0);
        chk("hz_exe_wb",     bus.EXE_WB_EN,   32'd0);
        chk("hz_mem_dest",   bus.MEM_Dest,    32'd3);
        chk("hz_stall",      bus.stall_cnt,   32'd1);
        chk("hz_flush",      bus.flush_cnt,   32'd0);
        chk("hz_hzmem",      bus.HZ_MEM_WB_EN, {31'd0, exp_hz_mem});

        // Hazard and Flush together: only the flush counter moves.
        drive(4'd9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        chk("hf_exe_dest",   bus.EXE_Dest,    32'd0);
        chk("hf_exe_mr",     bus.EXE_MEM_R_EN, 32'd0);
        chk("hf_wb_dest",    bus.WB_Dest,     32'd3);
        chk("hf_flush",      bus.flush_cnt,   32'd1);
        chk("hf_stall",      bus.stall_cnt,   32'd1);

        // Load Dest=6 into EXE.
        drive(4'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("ld_exe_dest",   bus.EXE_Dest,    32'd6);
        chk("ld_exe_mr",     bus.EXE_MEM_R_EN, 32'd1);
        chk("ld_hz_exe",     bus.HZ_EXE_WB_EN, 32'd1);
        chk("ld_hz_mem",     bus.HZ_MEM_WB_EN, 32'd0);
        chk("ld_wb_dest",    bus.WB_Dest,     32'd0);

        // Freeze for 3 cycles with Hazard (and Flush on the last): nothing moves.
        snap = all_out();
        drive(4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        chk("fz1_outs",      all_out(),       snap);
        chk("fz1_stall",     bus.stall_cnt,   32'd1);
        tick();
        chk("fz2_outs",      all_out(),       snap);
        drive(4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        chk("fz3_outs",      all_out(),       snap);
        chk("fz3_exe_dest",  bus.EXE_Dest,    32'd6);
        chk("fz3_stall",     bus.stall_cnt,   32'd1);
        chk("fz3_flush",     bus.flush_cnt,   32'd1);

        // Release freeze with a plain bubble.
        drive(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("rl_exe_dest",   bus.EXE_Dest,    32'd0);
        chk("rl_mem_dest",   bus.MEM_Dest,    32'd6);
        chk("s_stall_pre",   bus_s.stall_cnt, 32'd1);

        // Five stall cycles: wide counter 1->6, narrow counter saturates at 3.
        drive(4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        chk("s_stall_sat",   bus_s.stall_cnt, 32'd3);
        tick();
        tick();
        tick();
        chk("s_stall_hold",  bus_s.stall_cnt, 32'd3);
        chk("b_stall_6",     bus.stall_cnt,   32'd6);
        chk("s_flush",       bus_s.flush_cnt, 32'd1);

        // Mid-operation reset between edges clears everything immediately.
        drive(4'hA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("pre_rst_exe",   bus.EXE_Dest,    32'd10);
        rst_n = 1'b0;
        #1;
        chk("mr_outs",       all_out(),       32'd0);
        chk("mr_stall",      bus.stall_cnt,   32'd0);
        chk("mr_flush",      bus.flush_cnt,   32'd0);
        chk("mr_s_stall",    bus_s.stall_cnt, 32'd0);
        #1;
        rst_n = 1'b1;
        tick();
        chk("post_exe_dest", bus.EXE_Dest,    32'd10);
        chk("post_mem_dest", bus.MEM_Dest,    32'd0);
        chk("post_wb_dest",  bus.WB_Dest,     32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dest_pipe_tracker.md
DEST_PIPE_TRACKER -- requirements
Module: dest_pipe_tracker

Interface
REQ-001 Parameter REG_W, 4, register-index width for all Dest ports.
REQ-002 Parameter CNT_W, 16, width of the stall and flush counters.
REQ-003 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 Port: ID_Dest  in  REG_W  destination register of the instruction in ID.
REQ-006 Port: ID_WB_EN  in  1  ID instruction writes the register file.
REQ-007 Port: ID_MEM_R_EN  in  1  ID instruction is a load.
REQ-008 Port: Hazard  in  1  hazard-unit stall request for the current cycle.
REQ-009 Port: Flush  in  1  taken branch resolved in EXE; squash the ID instruction.
REQ-010 Port: Freeze  in  1  global memory wait; the whole pipeline holds.
REQ-011 Port: EXE_Dest, MEM_Dest, WB_Dest  out  REG_W each  destinations held in EXE/MEM/WB.
REQ-012 Port: EXE_WB_EN, MEM_WB_EN, WB_WB_EN  out  1 each  true write-enables per stage.
REQ-013 Port: EXE_MEM_R_EN  out  1  EXE instruction is a load.
REQ-014 Port: HZ_EXE_WB_EN, HZ_MEM_WB_EN  out  1 each  write-enables presented to the hazard unit.
REQ-015 Port: stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Function
REQ-016 The block shall be a three-slot shift pipeline (EXE, MEM, WB); each slot holds {Dest, WB_EN, MEM_R_EN}.
REQ-017 Normal cycle (Freeze=0, Hazard=0, Flush=0): EXE<=ID inputs, MEM<=EXE, WB<=MEM; one-cycle latency per stage.
REQ-018 When Hazard=1 and Freeze=0, EXE shall load a bubble (all fields 0), and MEM and WB shall advance normally.
REQ-019 When Flush=1 and Freeze=0, EXE shall load a bubble regardless of Hazard, and MEM and WB shall advance normally.
REQ-020 When Freeze=1, all three slots and both counters shall hold, regardless of Hazard and Flush.
REQ-021 The stall counter shall increment when Hazard=1, Flush=0 and Freeze=0.
REQ-022 The flush counter shall increment when Flush=1 and Freeze=0; when Hazard and Flush are both 1, only the flush counter shall increment.
REQ-023 Both counters shall saturate at 2^CNT_W-1 and never wrap.
REQ-024 Every output shall be driven directly from registers; no combinational path shall exist from any input to any output.
REQ-025 A bubble slot shall always read Dest=0 with both enables 0.

Reset
REQ-026 When rst_n=0, all slots and counters shall clear to 0 immediately, independent of clk, so every output reads 0.
REQ-027 Reset asserted mid-operation shall discard all in-flight entries; the first rising edge after deassertion shall apply normal REQ-017..020 rules.

Configuration
REQ-028 Macro FWD_EN shall select forwarding-aware hazard outputs.
REQ-029 With FWD_EN defined: HZ_EXE_WB_EN=EXE_WB_EN&EXE_MEM_R_EN and HZ_MEM_WB_EN=0, so only load-use stalls occur.
REQ-030 With FWD_EN undefined: HZ_EXE_WB_EN=EXE_WB_EN and HZ_MEM_WB_EN=MEM_WB_EN.
REQ-031 The true stage outputs and the counters shall be identical in both builds.

Structure
REQ-032 Shared pipeline package shall hold REG_W, the stage-entry struct {Dest, WB_EN, MEM_R_EN}, and the bubble constant.
REQ-033 One sub-module, sat_counter (CNT_W, enable, hold), shall be instantiated twice, once per counter.

Verification
REQ-034 Reset, then ID_Dest=5, WB_EN=1 for 1 cycle -> EXE_Dest=5 at edge 1, MEM_Dest=5 at edge 2, WB_Dest=5 at edge 3, then zeros follow.
REQ-035 EXE holds Dest=3 and Hazard=1 for 1 cycle -> EXE=bubble, MEM_Dest=3, stall_cnt=1.
REQ-036 Hazard=1 and Flush=1 together -> EXE=bubble, flush_cnt=1, stall_cnt unchanged.
REQ-037 Freeze=1 for 3 cycles with Hazard=1 -> all outputs and counters unchanged.
REQ-038 With FWD_EN, EXE non-load with WB_EN=1 -> HZ_EXE_WB_EN=0; EXE load -> HZ_EXE_WB_EN=1; HZ_MEM_WB_EN always 0.
REQ-039 CNT_W=2 with 5 stall cycles -> stall_cnt=3; assert rst_n=0 between edges -> all outputs 0 before the next edge.
